mfe_host_io: RTL and testbench
==============================

# mfe_host_io

Host-side frame controller for the median filter engine (MFE). It accepts a raster-order 8-bit pixel stream and writes it into the grayscale image memory, then hands the frame to the MFE via `ready`/`busy`. Once the MFE finishes, it reads the result memory back and emits the filtered frame as a valid/ready stream. It drives the write port of the image memory and the read port of the result memory, the opposite ends of the ports the MFE uses.

## Interface
Parameters:
- `IMG_W`, 128: image width in pixels.
- `IMG_H`, 128: image height in pixels.
- `AW`, 14: address width; must equal log2(`IMG_W`*`IMG_H`).

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  input pixel valid.
- `s_data`  in  8  input pixel in raster order, address 0 first.
- `s_ready`  out  1  the block can accept an input pixel.
- `gwen`  out  1  grayscale image memory write enable.
- `gaddr`  out  AW  grayscale image memory write address.
- `gdata`  out  8  grayscale image memory write data.
- `mfe_ready`  out  1  frame loaded; request to the MFE to start.
- `mfe_busy`  in  1  MFE busy flag.
- `raddr`  out  AW  result memory read address.
- `rdata`  in  8  result memory read data; valid on the cycle after `raddr` is registered.
- `m_valid`  out  1  output pixel valid.
- `m_data`  out  8  filtered output pixel.
- `m_last`  out  1  output pixel is the last one, index `IMG_W`*`IMG_H`-1.
- `m_ready`  in  1  downstream accepts the output pixel.
- `done`  out  1  one-cycle pulse when the last output pixel is accepted.

## Operation
- N = `IMG_W`*`IMG_H`. `cnt` is an AW-bit index that is cleared whenever a new phase starts.
- States:
  - S_IDLE: entered from reset. Goes to S_LOAD on the next cycle.
  - S_LOAD: `s_ready`=1.
    - On `s_valid`&&`s_ready`, register `gaddr`<=`cnt`, `gdata`<=`s_data`, `gwen`<=1, and increment `cnt`. `gwen` is 0 on any cycle without a handshake.
    - On the handshake where `cnt`==N-1, clear `cnt` and go to S_START.
  - S_START: `mfe_ready`=1, `s_ready`=0. Go to S_WAIT when `mfe_busy`==1.
    - `mfe_ready` is asserted for at least 1 cycle, even if `mfe_busy` is already high on entry.
  - S_WAIT: `mfe_ready`=0. Go to S_RD_REQ when `mfe_busy`==0.
  - S_RD_REQ: `raddr`<=`cnt`. Go to S_RD_RES.
  - S_RD_RES: `m_data`<=`rdata`, `m_valid`<=1, `m_last`<=(`cnt`==N-1). Go to S_OUT.
  - S_OUT: hold `m_valid`, `m_data` and `m_last` stable until `m_ready`==1. On that handshake, `m_valid`<=0.
    - If `m_last`: `done`<=1 for 1 cycle, clear `cnt`, go to S_LOAD.
    - Otherwise increment `cnt` and go to S_RD_REQ.
- Once `s_ready` is low, `s_valid` is ignored; pixels offered outside S_LOAD are not consumed.
- `m_valid` never drops without a handshake, and `m_data` never changes while `m_valid`=1.
- An asynchronous `reset` mid-operation forces S_IDLE, `cnt`=0 and all outputs to 0. A partial frame is discarded. Memory contents are not touched.
- `cnt` arithmetic is unsigned modulo 2^AW; with the defaults, N-1=16383 is the terminal value.

## Timing
- Reset value of every output is 0, including `s_ready`, which rises 1 cycle after `reset` deasserts.
- Load: at most 1 pixel per cycle. The memory write (`gwen`) occurs on the cycle after the handshake. A full frame takes N cycles with `s_valid` held high.
- `mfe_ready` rises on the cycle after the final write handshake. This is the same cycle the final `gwen` is high.
- Readback: if `mfe_busy` is sampled low at cycle T in S_WAIT, `raddr`=0 is valid at T+2 and `m_valid` rises at T+3.
- Output throughput: 1 pixel per 3 cycles with `m_ready` held high.
- `done` is high on the cycle after the last output handshake; `s_ready` is high that same cycle.

## Test plan
- Reset and idle: assert `reset` for 3 cycles with `s_valid`=1. All outputs must be 0 throughout. `s_ready` must be 1 exactly 1 cycle after deassert.
- Full load: stream pixels with value (i mod 256) for i=0..16383.
  - Required: 16384 `gwen` pulses, `gaddr`=i, `gdata`=i mod 256.
  - Required: `mfe_ready` asserted on the cycle after the final handshake, with `s_ready`=0 thereafter.
- Start handshake: keep `mfe_busy`=1 already on entry to S_START. `mfe_ready` must be high for exactly 1 cycle. Then with `mfe_busy` low 50 cycles later, `m_valid` must rise 3 cycles after busy is sampled low.
- Readback with backpressure: result memory preloaded with rdata=(addr*3) mod 256, `m_ready` toggled randomly.
  - Required: 16384 beats in order, `m_data` stable while stalled, `m_last` only on beat 16383.
  - Required: `done` 1 cycle after that beat, and `s_ready`=1 on the same cycle as `done`.
- Back-to-back frames: a second frame loaded immediately after `done` must write from `gaddr`=0 and produce its own complete readback.
- Mid-frame reset: assert `reset` after 5000 loaded pixels. After deassert, a full new frame must load from `gaddr`=0 with no stale `mfe_ready`.

Source files
------------

// File: rtl/mfe_host_io.sv
// Host-side frame controller for the median filter engine: loads a raster pixel stream into image memory, starts the MFE, streams the result back out.
// Latency: pixel write 1 cycle after handshake; readback pixel appears 3 cycles after busy is sampled low, then 1 pixel per 3 cycles.
// Backpressure: s_ready only in the load phase; m_valid/m_data held stable until m_ready, readback stalls meanwhile.
module mfe_host_io #(
   parameter int IMG_W = 128,
   parameter int IMG_H = 128,
   parameter int AW    = 14
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          s_valid,
   input  logic [7:0]    s_data,
   output logic          s_ready,
   output logic          gwen,
   output logic [AW-1:0] gaddr,
   output logic [7:0]    gdata,
   output logic          mfe_ready,
   input  logic          mfe_busy,
   output logic [AW-1:0] raddr,
   input  logic [7:0]    rdata,
   output logic          m_valid,
   output logic [7:0]    m_data,
   output logic          m_last,
   input  logic          m_ready,
   output logic          done
);

   // Index of the final pixel of a frame; cnt wraps modulo 2^AW.
   localparam logic [AW-1:0] LAST = AW'(IMG_W * IMG_H - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT,
      S_RD_REQ,
      S_RD_RES,
      S_OUT
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] gaddr_q, gaddr_d;
   logic [7:0]    gdata_q, gdata_d;
   logic          gwen_q, gwen_d;
   logic [AW-1:0] raddr_q, raddr_d;
   logic [7:0]    m_data_q, m_data_d;
   logic          m_valid_q, m_valid_d;
   logic          m_last_q, m_last_d;
   logic          done_q, done_d;

   logic load_hs;
   logic out_hs;

   // s_ready is a pure state decode, so it is low in S_IDLE and rises one cycle after reset.
   assign s_ready   = (state_q == S_LOAD);
   assign mfe_ready = (state_q == S_START);
   assign load_hs   = s_ready && s_valid;
   assign out_hs    = (state_q == S_OUT) && m_ready;

   assign gwen    = gwen_q;
   assign gaddr   = gaddr_q;
   assign gdata   = gdata_q;
   assign raddr   = raddr_q;
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_last  = m_last_q;
   assign done    = done_q;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; S_START always lasts at least one cycle so mfe_ready is never missed.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   state_d = S_LOAD;
         S_LOAD:   if (load_hs && (cnt_q == LAST)) state_d = S_START;
         S_START:  if (mfe_busy) state_d = S_WAIT;
         S_WAIT:   if (!mfe_busy) state_d = S_RD_REQ;
         S_RD_REQ: state_d = S_RD_RES;
         S_RD_RES: state_d = S_OUT;
         S_OUT:    if (out_hs) state_d = m_last_q ? S_LOAD : S_RD_REQ;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath and registered outputs; gwen and done are single-cycle strobes.
   always_comb begin
      cnt_d     = cnt_q;
      gaddr_d   = gaddr_q;
      gdata_d   = gdata_q;
      gwen_d    = 1'b0;
      raddr_d   = raddr_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: cnt_d = '0;
         S_LOAD: begin
            if (load_hs) begin
               gwen_d  = 1'b1;
               gaddr_d = cnt_q;
               gdata_d = s_data;
               cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end
         end
         S_RD_REQ: raddr_d = cnt_q;
         S_RD_RES: begin
            m_data_d  = rdata;
            m_valid_d = 1'b1;
            m_last_d  = (cnt_q == LAST);
         end
         S_OUT: begin
            if (out_hs) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               if (m_last_q) begin
                  done_d = 1'b1;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; reset clears the index and drives every output low, discarding any partial frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         gaddr_q   <= '0;
         gdata_q   <= '0;
         gwen_q    <= 1'b0;
         raddr_q   <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         gaddr_q   <= gaddr_d;
         gdata_q   <= gdata_d;
         gwen_q    <= gwen_d;
         raddr_q   <= raddr_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_mfe_host_io.sv
// Self-checking bench for mfe_host_io on a reduced 32x32 frame.
// Write and readback expectations are queued by the stimulus and popped by a negedge monitor.
// Downstream m_ready is randomised to exercise output stalls.
module tb_mfe_host_io;
   localparam int IMG_W = 32;
   localparam int IMG_H = 32;
   localparam int AW    = 10;
   localparam int N     = IMG_W * IMG_H;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          s_valid = 1'b0;
   logic [7:0]    s_data = 8'h00;
   logic          s_ready;
   logic          gwen;
   logic [AW-1:0] gaddr;
   logic [7:0]    gdata;
   logic          mfe_ready;
   logic          mfe_busy = 1'b0;
   logic [AW-1:0] raddr;
   logic [7:0]    rdata;
   logic          m_valid;
   logic [7:0]    m_data;
   logic          m_last;
   logic          m_ready = 1'b0;
   logic          done;

   logic [7:0]    res_mem [N];
   logic [AW+7:0] wr_q [$];
   logic [8:0]    rd_q [$];

   int n_checks = 0;
   int n_fail   = 0;
   int frames_done = 0;

   logic          prev_vld = 1'b0;
   logic          prev_rdy = 1'b0;
   logic          prev_last = 1'b0;
   logic [7:0]    prev_dat = 8'h00;
   logic          exp_done = 1'b0;
   logic [AW+7:0] we;
   logic [8:0]    re;

   mfe_host_io #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .gwen      (gwen),
      .gaddr     (gaddr),
      .gdata     (gdata),
      .mfe_ready (mfe_ready),
      .mfe_busy  (mfe_busy),
      .raddr     (raddr),
      .rdata     (rdata),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_last    (m_last),
      .m_ready   (m_ready),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Result memory read data follows the registered read address.
   assign rdata = res_mem[raddr];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Random downstream backpressure.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: memory writes, output beats, stall stability and the done pulse.
   always @(negedge clk) begin
      if (reset) begin
         prev_vld = 1'b0;
         exp_done = 1'b0;
      end else begin
         if (exp_done) begin
            check("done_pulse", done, 1);
            check("s_ready_at_done", s_ready, 1);
            exp_done = 1'b0;
            frames_done++;
         end else if (done) begin
            check("done_spurious", done, 0);
         end
         if (gwen) begin
            if (wr_q.size() == 0) begin
               check("gwen_unexpected", gwen, 0);
            end else begin
               we = wr_q.pop_front();
               check("gaddr", gaddr, we[AW+7:8]);
               check("gdata", gdata, we[7:0]);
            end
         end
         if (prev_vld && !prev_rdy) begin
            check("m_valid_hold", m_valid, 1);
            check("m_data_stable", m_data, prev_dat);
            check("m_last_stable", m_last, prev_last);
         end
         if (m_valid && m_ready) begin
            if (rd_q.size() == 0) begin
               check("beat_unexpected", m_valid, 0);
            end else begin
               re = rd_q.pop_front();
               check("m_data", m_data, re[7:0]);
               check("m_last", m_last, re[8]);
               if (re[8]) exp_done = 1'b1;
            end
         end
         prev_vld  = m_valid;
         prev_rdy  = m_ready;
         prev_dat  = m_data;
         prev_last = m_last;
      end
   end

   // Streams n pixels (value i mod 256) with random idle gaps, queuing each accepted write.
   task automatic load_frame(input int n, input int gap_pct);
      int i = 0;
      int cyc = 0;
      while (i < n && cyc < n * 8 + 100) begin
         s_valid = ($urandom_range(0, 99) >= gap_pct);
         s_data  = 8'(i % 256);
         @(negedge clk);
         check("mfe_ready_during_load", mfe_ready, 0);
         if (s_valid && s_ready) begin
            wr_q.push_back({AW'(i), 8'(i % 256)});
            i++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      s_valid = 1'b0;
      check("load_complete", i, n);
   endtask

   task automatic prep_readback(input int seed);
      for (int a = 0; a < N; a++) begin
         res_mem[a] = 8'((a * 3 + seed) % 256);
         rd_q.push_back({(a == N - 1), 8'((a * 3 + seed) % 256)});
      end
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      int start = frames_done;
      while (frames_done == start && c < budget) begin
         @(posedge clk);
         c++;
      end
      #1;
      check("done_seen", (frames_done != start), 1);
      check("readback_all_beats", rd_q.size(), 0);
   endtask

   initial begin
      for (int a = 0; a < N; a++) res_mem[a] = 8'h00;

      // Reset with s_valid asserted: all outputs low.
      reset   = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'hA5;
      repeat (3) begin
         @(negedge clk);
         check("reset_outputs", ({s_ready, gwen, gaddr, gdata, mfe_ready, raddr,
                                  m_valid, m_data, m_last, done} != 0), 0);
      end
      @(posedge clk);
      #1;
      reset   = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      check("s_ready_idle", s_ready, 0);
      @(negedge clk);
      check("s_ready_rise", s_ready, 1);
      @(posedge clk);
      #1;

      // Frame 1: busy already high on entry to start, mfe_ready for one cycle.
      mfe_busy = 1'b1;
      load_frame(N, 0);
      s_valid = 1'b1;
      s_data  = 8'hEE;
      @(negedge clk);
      check("mfe_ready_after_load", mfe_ready, 1);
      check("s_ready_after_load", s_ready, 0);
      @(negedge clk);
      check("mfe_ready_one_cycle", mfe_ready, 0);
      check("s_ready_in_wait", s_ready, 0);
      check("writes_frame1", wr_q.size(), 0);
      prep_readback(0);
      repeat (50) @(posedge clk);
      #1;
      s_valid  = 1'b0;
      mfe_busy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("m_valid_t1", m_valid, 0);
      @(negedge clk);
      check("raddr_t2", raddr, 0);
      check("m_valid_t2", m_valid, 0);
      @(negedge clk);
      check("m_valid_t3", m_valid, 1);
      wait_done(N * 12);

      // Frame 2 back-to-back: busy low on entry, mfe_ready holds until busy rises.
      load_frame(N, 30);
      s_valid = 1'b1;
      s_data  = 8'h3C;
      @(negedge clk);
      check("mfe_ready_f2", mfe_ready, 1);
      repeat (3) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         check("mfe_ready_hold", mfe_ready, 1);
      end
      @(posedge clk);
      #1;
      mfe_busy = 1'b1;
      @(negedge clk);
      check("mfe_ready_busy_seen", mfe_ready, 1);
      @(negedge clk);
      check("mfe_ready_drop", mfe_ready, 0);
      check("writes_frame2", wr_q.size(), 0);
      prep_readback(7);
      repeat (10) @(posedge clk);
      #1;
      s_valid  = 1'b0;
      mfe_busy = 1'b0;
      wait_done(N * 12);

      // Mid-frame reset: partial frame discarded, next frame starts at address 0.
      load_frame(500, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("midreset_outputs", ({s_ready, gwen, mfe_ready, m_valid, done} != 0), 0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("partial_writes", wr_q.size(), 0);
      mfe_busy = 1'b1;
      load_frame(N, 10);
      @(negedge clk);
      check("mfe_ready_f3", mfe_ready, 1);
      @(negedge clk);
      check("mfe_ready_f3_drop", mfe_ready, 0);
      check("writes_frame3", wr_q.size(), 0);
      prep_readback(99);
      repeat (5) @(posedge clk);
      #1;
      mfe_busy = 1'b0;
      wait_done(N * 12);

      check("frames_done", frames_done, 3);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Global timeout.
   initial begin
      #(10 * 90000);
      n_fail++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
